// File: rtl/stream_pack.sv
// ---------------------------------------------------------------------------
// stream_pack
//
// Packs consecutive WIDTH-bit samples from a valid/ready stream into words of
// RATIO samples. The first sample of a word lands in the least-significant
// lane. A frame-end flag on the input flushes a partially filled word early:
// the unused upper lanes are zero and the word carries its lane count.
//
// Ports
//   i_clock      in   clock, rising edge
//   i_reset      in   synchronous, active-high reset
//   i_in_data    in   [WIDTH]        input sample
//   i_in_valid   in   input sample valid
//   i_in_last    in   sample ends a frame (qualified by i_in_valid)
//   o_in_ready   out  sample accepted this cycle when valid
//   o_out_data   out  [WIDTH*RATIO]  packed word, lane k = [k*WIDTH +: WIDTH]
//   o_out_count  out  [clog2(RATIO)+1] number of valid lanes, 1..RATIO
//   o_out_last   out  word ends a frame
//   o_out_valid  out  output word valid
//   i_out_ready  in   downstream accepts word
// ---------------------------------------------------------------------------
module stream_pack #(
    parameter int WIDTH = 16,
    parameter int RATIO = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_in_data,
    input  logic                       i_in_valid,
    input  logic                       i_in_last,
    output logic                       o_in_ready,
    output logic [WIDTH*RATIO-1:0]     o_out_data,
    output logic [$clog2(RATIO):0]     o_out_count,
    output logic                       o_out_last,
    output logic                       o_out_valid,
    input  logic                       i_out_ready
);

    localparam int IDX_W = $clog2(RATIO);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Stage 0: lane index and accumulator for the word being filled
    logic [IDX_W-1:0]        idx_p0;
    logic [WIDTH*RATIO-1:0]  acc_p0;
    logic [WIDTH*RATIO-1:0]  word_p0;

    // Stage 1: output register
    logic [WIDTH*RATIO-1:0]  data_p1;
    logic [CNT_W-1:0]        count_p1;
    logic                    last_p1;
    logic                    vld_p1;

    logic in_fire;
    logic completing;

    // The output register is free when empty or being drained this cycle, so
    // a completing sample can load it while the previous word leaves.
    assign o_in_ready = !i_reset && (!vld_p1 || i_out_ready);
    assign in_fire    = i_in_valid && o_in_ready;
    assign completing = (idx_p0 == LAST_IDX) || i_in_last;

    // Word as it would be emitted if this sample completes it: accumulated
    // lanes below idx, the incoming sample at idx, zeros above.
    always_comb begin
        word_p0 = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(idx_p0)) begin
                word_p0[k*WIDTH +: WIDTH] = acc_p0[k*WIDTH +: WIDTH];
            end else if (k == int'(idx_p0)) begin
                word_p0[k*WIDTH +: WIDTH] = i_in_data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            idx_p0 <= '0;
            acc_p0 <= '0;
        end else if (in_fire) begin
            if (completing) begin
                idx_p0 <= '0;
                acc_p0 <= '0;
            end else begin
                acc_p0[int'(idx_p0)*WIDTH +: WIDTH] <= i_in_data;
                idx_p0 <= idx_p0 + IDX_W'(1);
            end
        end
    end

    // Stage 0 -> stage 1: output register loads only on a completing sample
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_p1  <= '0;
            count_p1 <= '0;
            last_p1  <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (in_fire && completing) begin
            data_p1  <= word_p0;
            count_p1 <= {1'b0, idx_p0} + CNT_W'(1);
            last_p1  <= i_in_last;
            vld_p1   <= 1'b1;
        end else if (vld_p1 && i_out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign o_out_data  = data_p1;
    assign o_out_count = count_p1;
    assign o_out_last  = last_p1;
    assign o_out_valid = vld_p1;

endmodule

// File: tb/tb_stream_pack.sv
// ---------------------------------------------------------------------------
// tb_stream_pack
//
// Bench for stream_pack with WIDTH=16, RATIO=4. Inputs are driven on the
// falling edge; handshakes and outputs are observed 1 ns before each rising
// edge. A monitor turns every accepted input sample into expected words using
// a queue of pending samples, and pops/compares whenever a word is taken.
// ---------------------------------------------------------------------------
module tb_stream_pack;

    localparam int WIDTH = 16;
    localparam int RATIO = 4;

    logic                   clk;
    logic                   rst;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [WIDTH*RATIO-1:0] out_data;
    logic [$clog2(RATIO):0] out_count;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0]       pend_q[$];
    logic [WIDTH*RATIO-1:0] exp_data_q[$];
    int                     exp_cnt_q[$];
    logic                   exp_last_q[$];

    stream_pack #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .i_in_last  (in_last),
        .o_in_ready (in_ready),
        .o_out_data (out_data),
        .o_out_count(out_count),
        .o_out_last (out_last),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Apply inputs at the falling edge, then move to the observation point
    // just before the next rising edge.
    task automatic step(input logic rs, input logic v, input logic [WIDTH-1:0] d,
                        input logic l, input logic r);
        @(negedge clk);
        rst       = rs;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #4;
    endtask

    task automatic expect_word(input string name, input logic [63:0] d, input int c,
                               input logic l);
        check({name, " valid"}, 64'(out_valid), 64'(1));
        check({name, " data"},  64'(out_data),  d);
        check({name, " count"}, 64'(out_count), 64'(c));
        check({name, " last"},  64'(out_last),  64'(l));
    endtask

    // Reference model and scoreboard: samples accumulate until RATIO of them
    // are held or a frame ends; a reset drops everything in flight.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            pend_q.delete();
            exp_data_q.delete();
            exp_cnt_q.delete();
            exp_last_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected word: got 0x%0h, expected no word", out_data);
                end else begin
                    check("sb data",  64'(out_data),  exp_data_q.pop_front());
                    check("sb count", 64'(out_count), 64'(exp_cnt_q.pop_front()));
                    check("sb last",  64'(out_last),  64'(exp_last_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                pend_q.push_back(in_data);
                if (pend_q.size() == RATIO || in_last) begin
                    logic [WIDTH*RATIO-1:0] w;
                    w = '0;
                    for (int i = 0; i < pend_q.size(); i++)
                        w = w | ((WIDTH*RATIO)'(pend_q[i]) << (WIDTH * i));
                    exp_data_q.push_back(w);
                    exp_cnt_q.push_back(pend_q.size());
                    exp_last_q.push_back(in_last);
                    pend_q.delete();
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0]       src;
        logic [WIDTH*RATIO-1:0] held;
        int                     accepted;
        int                     n;
        int                     cycles;
        logic                   rr;
        logic                   vv;

        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0);
            check("reset in_ready",  64'(in_ready),  0);
            check("reset out_valid", 64'(out_valid), 0);
            check("reset out_data",  64'(out_data),  0);
            check("reset out_count", 64'(out_count), 0);
            check("reset out_last",  64'(out_last),  0);
        end

        // Idle
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 0, 1);
            check("idle in_ready",  64'(in_ready),  1);
            check("idle out_valid", 64'(out_valid), 0);
            check("idle out_data",  64'(out_data),  0);
        end

        // Full rate
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, WIDTH'(i), 0, 1);
            check("full_rate in_ready", 64'(in_ready), 1);
            if (i == 5) expect_word("full_rate w0", 64'h0004_0003_0002_0001, 4, 0);
        end
        step(0, 0, 0, 0, 1);
        expect_word("full_rate w1", 64'h0008_0007_0006_0005, 4, 0);
        step(0, 0, 0, 0, 1);
        check("full_rate drained", 64'(out_valid), 0);

        // Partial flush
        step(0, 1, 16'h00AA, 0, 1);
        step(0, 1, 16'h00BB, 1, 1);
        step(0, 0, 0, 0, 1);
        expect_word("flush2", 64'h0000_0000_00BB_00AA, 2, 1);
        step(0, 1, 16'h0011, 0, 1);
        step(0, 1, 16'h0022, 0, 1);
        step(0, 1, 16'h0033, 0, 1);
        step(0, 1, 16'h0044, 0, 1);
        step(0, 0, 0, 0, 1);
        expect_word("after_flush", 64'h0044_0033_0022_0011, 4, 0);
        step(0, 1, 16'h1234, 1, 1);
        step(0, 0, 0, 0, 1);
        expect_word("single", 64'h0000_0000_0000_1234, 1, 1);

        // Backpressure
        src = 16'd1;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, src, 0, 0);
            if (in_ready) begin
                accepted++;
                src++;
            end
        end
        check("bp accepted", 64'(accepted), 4);
        check("bp in_ready low", 64'(in_ready), 0);
        held = out_data;
        check("bp word", held, 64'h0004_0003_0002_0001);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, src, 0, 0);
            check("bp hold valid", 64'(out_valid), 1);
            check("bp hold data",  out_data, held);
            check("bp hold ready", 64'(in_ready), 0);
        end
        step(0, 1, src, 0, 1);
        check("bp resume", 64'(in_ready), 1);
        src++;
        while (src <= 16'd8) begin
            step(0, 1, src, 0, 1);
            check("bp stream ready", 64'(in_ready), 1);
            src++;
        end
        step(0, 0, 0, 0, 1);
        expect_word("bp w1", 64'h0008_0007_0006_0005, 4, 0);

        // Random: bursts of valid and ready, frame end every 7th sample
        n      = 0;
        cycles = 0;
        rr     = 1'b1;
        while ((n < 1000 || n % 7 != 0) && cycles < 20000) begin
            if ($urandom_range(0, 7) == 0) rr = ~rr;
            vv = ($urandom_range(0, 3) != 0);
            step(0, vv, WIDTH'($urandom), vv ? (n % 7 == 6) : 1'($urandom), rr);
            if (vv && in_ready) n++;
            cycles++;
        end
        check("random completed", 64'(cycles < 20000), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        check("random drained", 64'(exp_data_q.size()), 0);

        // Reset mid-word
        step(0, 1, 16'h0001, 0, 1);
        step(0, 1, 16'h0002, 0, 1);
        step(1, 0, 0, 0, 1);
        check("mid reset in_ready", 64'(in_ready), 0);
        step(0, 1, 16'h0005, 0, 1);
        check("post reset in_ready",  64'(in_ready),  1);
        check("post reset out_valid", 64'(out_valid), 0);
        check("post reset out_data",  64'(out_data),  0);
        check("post reset out_count", 64'(out_count), 0);
        step(0, 1, 16'h0006, 0, 1);
        step(0, 1, 16'h0007, 0, 1);
        step(0, 1, 16'h0008, 0, 1);
        check("mid reset no early word", 64'(out_valid), 0);
        step(0, 0, 0, 0, 1);
        expect_word("mid reset word", 64'h0008_0007_0006_0005, 4, 0);

        // Everything the model expects must have come out
        cycles = 0;
        while (exp_data_q.size() != 0 && cycles < 50) begin
            step(0, 0, 0, 0, 1);
            cycles++;
        end
        step(0, 0, 0, 0, 1);
        check("final queue empty", 64'(exp_data_q.size()), 0);
        check("final idle", 64'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_pack.md
# stream_pack

Packs consecutive WIDTH-bit samples from a valid/ready stream into RATIO-sample words, first sample in the least-significant lane. It sits directly upstream of the skid buffer and feeds the skid's input port. The skid's registered ready breaks the combinational ready path this block has. A frame-end flag `i_in_last` flushes a partially filled word, zero-padded, with a sample count.

## Interface
- `WIDTH`, 16: sample width in bits.
- `RATIO`, 4: samples per output word; must be ≥ 2.
- `i_clock`  in  1: clock; all logic on rising edge.
- `i_reset`  in  1: reset i_reset, synchronous, active-high; clock i_clock.
- `i_in_data`  in  WIDTH: input sample.
- `i_in_valid`  in  1: input sample valid.
- `i_in_last`  in  1: sample is last of frame; qualified by valid.
- `o_in_ready`  out  1: block accepts sample this cycle.
- `o_out_data`  out  WIDTH*RATIO: packed word; lane k = bits [k*WIDTH +: WIDTH].
- `o_out_count`  out  $clog2(RATIO)+1: number of valid lanes, 1..RATIO.
- `o_out_last`  out  1: word ends a frame.
- `o_out_valid`  out  1: output word valid.
- `i_out_ready`  in  1: downstream accepts word.

## Operation
- Input transfer: `i_in_valid & o_in_ready` at a rising edge. Output transfer: `o_out_valid & i_out_ready`.
- `o_in_ready = !i_reset & (!o_out_valid | i_out_ready)`. This is combinational from `i_out_ready` and independent of `i_in_valid` and `i_in_last`.
- State:
  - Lane index `idx` (0..RATIO-1); idx = 0 is the EMPTY state, otherwise FILLING.
  - Accumulator holding lanes 0..RATIO-2.
  - Output register holding data, count, last and valid.
- Non-completing transfer (`idx != RATIO-1` and `!i_in_last`): write the sample into lane `idx`, then `idx <= idx+1`.
- Completing transfer (`idx == RATIO-1` or `i_in_last`):
  - Output data: accumulator lanes 0..idx-1, the new sample in lane `idx`, and lanes above `idx` forced to 0.
  - Count = `idx+1`; last = `i_in_last`; `o_out_valid <= 1`.
  - Then `idx <= 0` and the accumulator is cleared to 0.
- Output register update:
  - Loads only on a completing transfer.
  - Otherwise `o_out_valid <= 0` on an output transfer.
  - Data, count and last are held stable while `o_out_valid & !i_out_ready`.
- Simultaneous output transfer and completing input transfer: the new word loads and `o_out_valid` stays 1, giving back-to-back words with no bubble.
- `i_in_last` with `i_in_valid` low is ignored.
- `i_in_data` and `i_in_last` are ignored when no transfer occurs.

## Timing
- Reset (synchronous):
  - `o_out_valid`, `o_out_last` = 0; `o_out_data` = 0; `o_out_count` = 0.
  - `idx` = 0; accumulator = 0.
  - `o_in_ready` = 0 while `i_reset` is high and 1 in the first cycle after release.
- Reset mid-word discards the accumulator and any pending output word; no partial word is ever emitted.
- Latency: a word is valid in the cycle after the edge of its completing input transfer.
- Throughput: one sample per cycle sustained when `i_out_ready` is held high; one word per RATIO cycles, or per frame end if sooner.
- Stall: with the output register full and `i_out_ready` low, `o_in_ready` is 0. When `i_out_ready` rises, input acceptance resumes in the same cycle.
- `o_out_count` is meaningful only while `o_out_valid` is high; it holds its last value otherwise.

## Test plan
All scenarios use WIDTH=16, RATIO=4.
- **Idle:** reset, then 100 cycles with no valid → `o_out_valid` never 1; `o_in_ready` = 1 from the first cycle after reset; all outputs 0.
- **Full rate:** ready high, samples 0x0001..0x0008 on consecutive cycles →
  - word 0x0004_0003_0002_0001 valid the cycle after the 4th beat, then word 0x0008_0007_0006_0005;
  - count 4, last 0 on both;
  - `o_in_ready` never drops.
- **Partial flush:** 0x00AA, then 0x00BB with last →
  - word 0x0000_0000_00BB_00AA, count 2, last 1;
  - following 0x0011, 0x0022, 0x0033, 0x0044 → word 0x0044_0033_0022_0011, count 4, last 0.
  - Also cover: single beat 0x1234 with last → count 1, word 0x0000_0000_0000_1234.
- **Backpressure:** `i_out_ready` low, valid held high with an incrementing source →
  - exactly 4 samples accepted, then `o_in_ready` = 0;
  - output word stable for 20 cycles;
  - raise ready → word taken, acceptance resumes that cycle;
  - sequence continuous with no loss or duplication.
- **Random:** random valid and random ready bursts over 1000 samples, with last on every 7th sample → unpacked output equals the input sequence; counts follow 4, then 3 at each frame end.
- **Reset mid-word:** accept 0x0001, 0x0002, assert reset 1 cycle, then send 0x0005..0x0008 → only word 0x0008_0007_0006_0005 emitted, count 4.
